// File: rtl/ebi_pkg.sv
// Shared register-map constants for the EBI register slave. The bridge's
// software model uses the same offsets and FIFO_STAT bit positions.
package ebi_pkg;

    // Register offsets within the 16-word window
    localparam logic [3:0] OFF_ID        = 4'h0;
    localparam logic [3:0] OFF_SCRATCH   = 4'h1;
    localparam logic [3:0] OFF_CTRL      = 4'h2;
    localparam logic [3:0] OFF_STATUS    = 4'h3;
    localparam logic [3:0] OFF_FIFO_DATA = 4'h4;
    localparam logic [3:0] OFF_FIFO_STAT = 4'h5;
    localparam logic [3:0] OFF_TICK      = 4'h6;
    localparam logic [3:0] OFF_WR_COUNT  = 4'h7;

    // FIFO_STAT layout: {ovf, unf, 8'b0, level[5:0]}
    localparam int FSTAT_OVF_BIT = 15;
    localparam int FSTAT_UNF_BIT = 14;
    localparam int LVL_W         = 6;

    // CTRL bits that gate the interrupt sources
    localparam int CTRL_IRQ_LVL_BIT  = 0;
    localparam int CTRL_IRQ_FLAG_BIT = 1;

    // Read-side transaction sequencer
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_LATCH = 2'd1,
        RD_DRIVE = 2'd2
    } rd_state_e;

    // Packs the FIFO status word returned at OFF_FIFO_STAT
    function automatic logic [15:0] fifo_stat(input logic ovf,
                                              input logic unf,
                                              input logic [LVL_W-1:0] lvl);
        return {ovf, unf, 8'h00, lvl};
    endfunction

endpackage

// File: rtl/ebi_reg_slave_if.sv
// EBI bus bundle: asynchronous-style strobes from the master, read data back.
interface ebi_reg_slave_if;
    logic        ebi_cs;
    logic        ebi_rden;
    logic        ebi_wren;
    logic [15:0] ebi_addr;
    logic [15:0] ebi_wdata;
    logic [15:0] ebi_rdata;

    modport master (
        output ebi_cs, ebi_rden, ebi_wren, ebi_addr, ebi_wdata,
        input  ebi_rdata
    );

    modport slave (
        input  ebi_cs, ebi_rden, ebi_wren, ebi_addr, ebi_wdata,
        output ebi_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes when full and pops when
// empty are ignored here; the caller records the overflow/underflow flags.
module sync_fifo
    import ebi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    // Empty FIFO reads as zero so an underflowing pop returns 16'h0000
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and level bookkeeping; pointers wrap because DEPTH is a power of two
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
        end
    end

    // Storage write
    // NOTE: the array has no reset; contents are only observable through the
    // pointers, which are reset, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/ebi_reg_slave.sv
// Register slave on an external bus interface: eight registers in a 16-word
// window, a data FIFO, a free-running tick counter and a level/flag interrupt.
// Strobes are edge-detected so a long strobe performs exactly one access.
module ebi_reg_slave
    import ebi_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [15:0] ID_VALUE   = 16'h5A01,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ebi_reg_slave_if.slave        bus,
    input  logic [15:0]           status_in,
    output logic [15:0]           ctrl_out,
    output logic                  irq
);

    logic             w_hit;
    logic [3:0]       w_off;
    logic             w_wr_cond;
    logic             w_rd_cond;
    logic             w_wr_evt;
    logic             w_rd_evt;
    logic             w_push;
    logic             w_pop;
    logic             w_latch;
    logic [15:0]      w_rd_mux;
    logic [15:0]      w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [LVL_W-1:0] w_level;
    rd_state_e        w_next_state;

    rd_state_e        r_state;
    logic             r_wr_cond;
    logic             r_rd_cond;
    logic [3:0]       r_rd_off;
    logic [15:0]      r_rdata;
    logic [15:0]      r_scratch;
    logic [15:0]      r_ctrl;
    logic [15:0]      r_status;
    logic [15:0]      r_tick;
    logic [15:0]      r_wr_count;
    logic             r_ovf;
    logic             r_unf;
    logic             r_irq;

    assign w_hit     = ~bus.ebi_cs && (bus.ebi_addr[15:4] == BASE_ADDR[15:4]);
    assign w_off     = bus.ebi_addr[3:0];
    assign w_wr_cond = w_hit & ~bus.ebi_wren;
    // A write strobe masks the read strobe, so both low means write only
    assign w_rd_cond = w_hit & ~bus.ebi_rden & bus.ebi_wren;
    assign w_wr_evt  = w_wr_cond & ~r_wr_cond;
    assign w_rd_evt  = w_rd_cond & ~r_rd_cond;
    assign w_push    = w_wr_evt && (w_off == OFF_FIFO_DATA);

    assign bus.ebi_rdata = r_rdata;
    assign ctrl_out      = r_ctrl;
    assign irq           = r_irq;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.ebi_wdata),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_level)
    );

    // Strobe history for edge detection; reset to "already active" so a strobe
    // that is low when reset releases is ignored until it goes high again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cond <= 1'b1;
            r_rd_cond <= 1'b1;
        end else begin
            r_wr_cond <= w_wr_cond;
            r_rd_cond <= w_rd_cond;
        end
    end

    // Read sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RD_IDLE;
        else     r_state <= w_next_state;
    end

    // Read sequencer next state: LATCH pops the FIFO and loads read data
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            RD_IDLE:  if (w_rd_evt) w_next_state = RD_LATCH;
            RD_LATCH: begin
                w_pop        = (r_rd_off == OFF_FIFO_DATA);
                w_latch      = 1'b1;
                w_next_state = RD_DRIVE;
            end
            RD_DRIVE: if (bus.ebi_rden || bus.ebi_cs) w_next_state = RD_IDLE;
            default:  w_next_state = RD_IDLE;
        endcase
    end

    // Read data selection for the offset captured at the read event
    always_comb begin
        w_rd_mux = '0;
        case (r_rd_off)
            OFF_ID:        w_rd_mux = ID_VALUE;
            OFF_SCRATCH:   w_rd_mux = r_scratch;
            OFF_CTRL:      w_rd_mux = r_ctrl;
            OFF_STATUS:    w_rd_mux = r_status;
            OFF_FIFO_DATA: w_rd_mux = w_fifo_dout;
            OFF_FIFO_STAT: w_rd_mux = fifo_stat(r_ovf, r_unf, w_level);
            OFF_TICK:      w_rd_mux = r_tick;
            OFF_WR_COUNT:  w_rd_mux = r_wr_count;
            default:       w_rd_mux = '0;
        endcase
    end

    // Offset capture at the read event and read-data register load in LATCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_off <= '0;
            r_rdata  <= '0;
        end else begin
            if (r_state == RD_IDLE && w_rd_evt) r_rd_off <= w_off;
            if (w_latch)                        r_rdata  <= w_rd_mux;
        end
    end

    // Writable registers and the accepted-write counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scratch  <= '0;
            r_ctrl     <= '0;
            r_wr_count <= '0;
        end else if (w_wr_evt) begin
            r_wr_count <= r_wr_count + 16'd1;
            case (w_off)
                OFF_SCRATCH: r_scratch <= bus.ebi_wdata;
                OFF_CTRL:    r_ctrl    <= bus.ebi_wdata;
                default:     ;
            endcase
        end
    end

    // Sticky FIFO error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push && w_fifo_full)
                r_ovf <= 1'b1;
            else if (w_wr_evt && w_off == OFF_FIFO_STAT && bus.ebi_wdata[FSTAT_OVF_BIT])
                r_ovf <= 1'b0;
            if (w_pop && w_fifo_empty)
                r_unf <= 1'b1;
            else if (w_wr_evt && w_off == OFF_FIFO_STAT && bus.ebi_wdata[FSTAT_UNF_BIT])
                r_unf <= 1'b0;
        end
    end

    // Status sampling, tick counter and registered interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
            r_tick   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= status_in;
            r_tick   <= r_tick + 16'd1;
            r_irq    <= (r_ctrl[CTRL_IRQ_LVL_BIT] && (w_level != '0)) ||
                        (r_ctrl[CTRL_IRQ_FLAG_BIT] && (r_ovf || r_unf));
        end
    end

endmodule

// File: tb/tb_ebi_reg_slave.sv
// Directed bench for ebi_reg_slave: register map, FIFO limits, interrupt
// timing, strobe edge detection and reset behaviour.
module tb_ebi_reg_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] status_in;
    logic [15:0] ctrl_out;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_wc = 16'h0000;
    logic [15:0] rd;
    logic [15:0] tick_a;

    ebi_reg_slave_if bus ();

    ebi_reg_slave dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n cycles, landing 1 ns after the rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.ebi_cs   = 1'b1;
        bus.ebi_rden = 1'b1;
        bus.ebi_wren = 1'b1;
    endtask

    task automatic ebi_write(input logic [15:0] addr, input logic [15:0] data,
                             input int hold = 3);
        bus.ebi_cs    = 1'b0;
        bus.ebi_addr  = addr;
        bus.ebi_wdata = data;
        bus.ebi_wren  = 1'b0;
        step(hold);
        bus_idle();
        step(2);
        exp_wc = exp_wc + 16'd1;
    endtask

    // Master samples 10 cycles after asserting the read strobe; 12 cycles total
    task automatic ebi_read(input logic [15:0] addr, output logic [15:0] data);
        bus.ebi_cs   = 1'b0;
        bus.ebi_addr = addr;
        bus.ebi_rden = 1'b0;
        step(10);
        data = bus.ebi_rdata;
        bus_idle();
        step(2);
    endtask

    initial begin
        status_in     = 16'h0000;
        bus.ebi_addr  = 16'h0000;
        bus.ebi_wdata = 16'h0000;
        bus_idle();

        // Reset with a write strobe already low: must not fire after release
        rst           = 1'b1;
        bus.ebi_cs    = 1'b0;
        bus.ebi_addr  = 16'h0001;
        bus.ebi_wdata = 16'hDEAD;
        bus.ebi_wren  = 1'b0;
        step(3);
        check("rst_rdata", bus.ebi_rdata, 16'h0000);
        check("rst_ctrl", ctrl_out, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        rst = 1'b0;
        step(5);
        bus_idle();
        step(2);
        ebi_read(16'h0001, rd); check("no_evt_after_rst", rd, 16'h0000);
        ebi_read(16'h0007, rd); check("wr_count_rst", rd, 16'h0000);
        ebi_read(16'h0005, rd); check("fifo_stat_rst", rd, 16'h0000);

        // Scratch and ID
        ebi_write(16'h0001, 16'h1234);
        ebi_read(16'h0001, rd); check("scratch", rd, 16'h1234);
        ebi_read(16'h0000, rd); check("id", rd, 16'h5A01);
        ebi_write(16'h0000, 16'h1111);
        ebi_read(16'h0000, rd); check("id_ro", rd, 16'h5A01);

        // CTRL output and readback
        ebi_write(16'h0002, 16'h00A4);
        check("ctrl_out", ctrl_out, 16'h00A4);
        ebi_read(16'h0002, rd); check("ctrl_rd", rd, 16'h00A4);
        ebi_write(16'h0002, 16'h0000);

        // STATUS samples status_in
        status_in = 16'h3C3C;
        ebi_read(16'h0003, rd); check("status", rd, 16'h3C3C);

        // Unmapped offsets
        ebi_write(16'h0009, 16'hFFFF);
        ebi_read(16'h0009, rd); check("unmapped_9", rd, 16'h0000);
        ebi_read(16'h000F, rd); check("unmapped_f", rd, 16'h0000);

        // FIFO fill, overflow, drain, underflow, flag clear
        for (int i = 0; i < 16; i++) ebi_write(16'h0004, 16'hA001 + 16'(i));
        ebi_write(16'h0004, 16'hBEEF);
        ebi_read(16'h0005, rd); check("fstat_full_ovf", rd, 16'h8010);
        for (int i = 0; i < 16; i++) begin
            ebi_read(16'h0004, rd);
            check($sformatf("pop_%0d", i), rd, 16'hA001 + 16'(i));
        end
        ebi_read(16'h0004, rd); check("pop_empty", rd, 16'h0000);
        ebi_read(16'h0005, rd); check("fstat_unf", rd, 16'hC000);
        ebi_write(16'h0005, 16'hC000);
        ebi_read(16'h0005, rd); check("fstat_clr", rd, 16'h0000);

        // Level interrupt: high 2 cycles after the write event
        ebi_write(16'h0002, 16'h0001);
        bus.ebi_cs    = 1'b0;
        bus.ebi_addr  = 16'h0004;
        bus.ebi_wdata = 16'h1234;
        bus.ebi_wren  = 1'b0;
        step(1); check("irq_t1", {15'b0, irq}, 16'h0000);
        step(1); check("irq_t2", {15'b0, irq}, 16'h0001);
        step(1);
        bus_idle();
        step(2);
        exp_wc = exp_wc + 16'd1;
        ebi_read(16'h0004, rd); check("irq_pop_data", rd, 16'h1234);
        check("irq_after_pop", {15'b0, irq}, 16'h0000);

        // Flag interrupt from underflow, cleared by FIFO_STAT write
        ebi_write(16'h0002, 16'h0002);
        ebi_read(16'h0004, rd);
        check("irq_unf", {15'b0, irq}, 16'h0001);
        ebi_write(16'h0005, 16'h4000);
        check("irq_unf_clr", {15'b0, irq}, 16'h0000);
        ebi_write(16'h0002, 16'h0000);

        // Long strobe writes once; deselected or out-of-window strobes do nothing
        ebi_write(16'h0004, 16'h7777, 20);
        ebi_read(16'h0005, rd); check("long_strobe_lvl", rd, 16'h0001);
        ebi_read(16'h0007, rd); check("long_strobe_wc", rd, exp_wc);
        bus.ebi_cs    = 1'b1;
        bus.ebi_addr  = 16'h0004;
        bus.ebi_wdata = 16'hBAD0;
        bus.ebi_wren  = 1'b0;
        step(5);
        bus_idle();
        step(2);
        bus.ebi_cs    = 1'b0;
        bus.ebi_addr  = 16'h0010;
        bus.ebi_wren  = 1'b0;
        step(5);
        bus_idle();
        step(2);
        bus.ebi_addr  = 16'h0014;
        bus.ebi_cs    = 1'b0;
        bus.ebi_wren  = 1'b0;
        step(5);
        bus_idle();
        step(2);
        ebi_read(16'h0005, rd); check("miss_lvl", rd, 16'h0001);
        ebi_read(16'h0007, rd); check("miss_wc", rd, exp_wc);
        ebi_read(16'h0004, rd); check("long_strobe_pop", rd, 16'h7777);

        // Both strobes low: write happens, read data untouched
        bus.ebi_cs    = 1'b0;
        bus.ebi_addr  = 16'h0001;
        bus.ebi_wdata = 16'h5555;
        bus.ebi_wren  = 1'b0;
        bus.ebi_rden  = 1'b0;
        step(10);
        check("both_rdata_hold", bus.ebi_rdata, 16'h7777);
        bus_idle();
        step(2);
        exp_wc = exp_wc + 16'd1;
        ebi_read(16'h0001, rd); check("both_scratch", rd, 16'h5555);
        ebi_read(16'h0007, rd); check("wc_total", rd, exp_wc);

        // Tick advances once per cycle: back-to-back reads start 12 cycles apart
        ebi_read(16'h0006, tick_a);
        ebi_read(16'h0006, rd); check("tick_delta", rd - tick_a, 16'd12);

        // Reset during LATCH of a pop aborts it
        ebi_write(16'h0002, 16'h0001);
        ebi_write(16'h0004, 16'h9999);
        check("pre_rst_irq", {15'b0, irq}, 16'h0001);
        bus.ebi_cs   = 1'b0;
        bus.ebi_addr = 16'h0004;
        bus.ebi_rden = 1'b0;
        step(1);
        rst = 1'b1;
        #2;
        check("mid_rst_rdata", bus.ebi_rdata, 16'h0000);
        check("mid_rst_ctrl", ctrl_out, 16'h0000);
        check("mid_rst_irq", {15'b0, irq}, 16'h0000);
        bus_idle();
        step(2);
        rst = 1'b0;
        step(2);
        ebi_read(16'h0005, rd); check("mid_rst_lvl", rd, 16'h0000);
        ebi_read(16'h0007, rd); check("mid_rst_wc", rd, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
